// File: rtl/ex_type_pkg.sv
// ex_type_pkg: shared VeriRISC types.
//   opcode_t  - 3-bit instruction opcode held in the IR.
//   state_t   - eight-phase instruction-cycle state of controller_m.
//   is_aluop  - true for opcodes that read an operand and load the accumulator.
package ex_type_pkg;

   typedef enum logic [2:0] {
      HLT = 3'd0,
      SKZ = 3'd1,
      ADD = 3'd2,
      AND = 3'd3,
      XOR = 3'd4,
      LDA = 3'd5,
      STO = 3'd6,
      JMP = 3'd7
   } opcode_t;

   typedef enum logic [2:0] {
      INST_ADDR  = 3'd0,
      INST_FETCH = 3'd1,
      INST_LOAD  = 3'd2,
      IDLE       = 3'd3,
      OP_ADDR    = 3'd4,
      OP_FETCH   = 3'd5,
      ALU_OP     = 3'd6,
      STORE      = 3'd7
   } state_t;

   function automatic logic is_aluop(opcode_t op);
      return op inside {ADD, AND, XOR, LDA};
   endfunction

endpackage

// File: rtl/controller_m_if.sv
// controller_m_if: decode inputs and strobe outputs of the sequencer.
//   opcode, zero          - from the IR / ALU into the controller.
//   mem_rd .. mem_wr      - strobes from the controller to the datapath.
//   slave  modport: controller side.  master modport: datapath / bench side.
interface controller_m_if;
   import ex_type_pkg::*;

   opcode_t opcode;
   logic    zero;
   logic    mem_rd;
   logic    load_ir;
   logic    halt;
   logic    inc_pc;
   logic    load_ac;
   logic    load_pc;
   logic    mem_wr;

   modport slave (
      input  opcode, zero,
      output mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr
   );

   modport master (
      output opcode, zero,
      input  mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr
   );

endinterface

// File: rtl/controller_m.sv
// controller_m: VeriRISC instruction-sequencing FSM.
//   clk  - rising-edge clock.
//   rst  - asynchronous active-high reset; forces INST_ADDR with all strobes 0.
//   bus  - controller_m_if.slave: opcode/zero in, memory/IR/PC/AC strobes out.
// One instruction takes eight clocks. Strobes are combinational decodes of the
// registered state, so they are stable across the falling edge where the ALU
// updates. HLT parks the FSM in OP_ADDR until reset.
module controller_m
   import ex_type_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   controller_m_if.slave  bus
);

   state_t state, next_state;
   logic   halted, halted_nxt;
   logic   aluop;
   logic   mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= INST_ADDR;
         halted <= 1'b0;
      end else begin
         state  <= next_state;
         halted <= halted_nxt;
      end
   end

   always_comb begin
      aluop      = is_aluop(bus.opcode);
      next_state = INST_ADDR;
      halted_nxt = halted;
      mem_rd     = 1'b0;
      load_ir    = 1'b0;
      halt       = 1'b0;
      inc_pc     = 1'b0;
      load_ac    = 1'b0;
      load_pc    = 1'b0;
      mem_wr     = 1'b0;
      case (state)
         INST_ADDR:  next_state = INST_FETCH;
         INST_FETCH: begin
            mem_rd     = 1'b1;
            next_state = INST_LOAD;
         end
         INST_LOAD: begin
            mem_rd     = 1'b1;
            load_ir    = 1'b1;
            next_state = IDLE;
         end
         IDLE: begin
            mem_rd     = 1'b1;
            load_ir    = 1'b1;
            next_state = OP_ADDR;
         end
         OP_ADDR: begin
            // Once halted, a later opcode change must not release the FSM;
            // the sticky flag keeps it parked until rst.
            if (halted || bus.opcode == HLT) begin
               halt       = 1'b1;
               halted_nxt = 1'b1;
               next_state = OP_ADDR;
            end else begin
               inc_pc     = 1'b1;
               next_state = OP_FETCH;
            end
         end
         OP_FETCH: begin
            mem_rd     = aluop;
            next_state = ALU_OP;
         end
         ALU_OP: begin
            mem_rd     = aluop;
            load_ac    = aluop;
            inc_pc     = (bus.opcode == SKZ) && bus.zero;
            load_pc    = (bus.opcode == JMP);
            next_state = STORE;
         end
         STORE: begin
            mem_rd     = aluop;
            load_ac    = aluop;
            inc_pc     = (bus.opcode == JMP);
            load_pc    = (bus.opcode == JMP);
            mem_wr     = (bus.opcode == STO);
            next_state = INST_ADDR;
         end
         default:    next_state = INST_ADDR;
      endcase
   end

   assign bus.mem_rd  = mem_rd;
   assign bus.load_ir = load_ir;
   assign bus.halt    = halt;
   assign bus.inc_pc  = inc_pc;
   assign bus.load_ac = load_ac;
   assign bus.load_pc = load_pc;
   assign bus.mem_wr  = mem_wr;

endmodule

// File: tb/tb_controller_m.sv
// tb_controller_m: directed checks of controller_m strobes per instruction phase.
// Output vector order: {mem_rd, load_ir, halt, inc_pc, load_ac, load_pc, mem_wr}.
module tb_controller_m;
   import ex_type_pkg::*;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   controller_m_if bus ();

   controller_m dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   function automatic logic [6:0] outs();
      return {bus.mem_rd, bus.load_ir, bus.halt, bus.inc_pc,
              bus.load_ac, bus.load_pc, bus.mem_wr};
   endfunction

   task automatic chk(input string tag, input logic [6:0] exp);
      logic [6:0] got;
      got = outs();
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b", tag, got, exp);
      end
   endtask

   // Called on a falling edge while the FSM sits in INST_ADDR; leaves it on the
   // falling edge of the following INST_ADDR.
   task automatic run_instr(input string name, input opcode_t op, input logic z,
                            input logic [6:0] e [8]);
      bus.opcode = op;
      bus.zero   = z;
      for (int c = 0; c < 8; c++) begin
         chk($sformatf("%s c%0d", name, c), e[c]);
         @(negedge clk);
      end
   endtask

   logic [6:0] t_add [8];
   logic [6:0] t_sto [8];
   logic [6:0] t_jmp [8];
   logic [6:0] t_skz1 [8];
   logic [6:0] t_skz0 [8];

   initial begin
      //           c0         c1         c2         c3         c4         c5         c6         c7
      t_add  = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000, 7'b0001000, 7'b1000000, 7'b1000100, 7'b1000100};
      t_sto  = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000, 7'b0001000, 7'b0000000, 7'b0000000, 7'b0000001};
      t_jmp  = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000, 7'b0001000, 7'b0000000, 7'b0000010, 7'b0001010};
      t_skz1 = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000, 7'b0001000, 7'b0000000, 7'b0001000, 7'b0000000};
      t_skz0 = '{7'b0000000, 7'b1000000, 7'b1100000, 7'b1100000, 7'b0001000, 7'b0000000, 7'b0000000, 7'b0000000};

      rst        = 1'b1;
      bus.opcode = ADD;
      bus.zero   = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset", 7'b0000000);
      rst = 1'b0;

      run_instr("add",  ADD, 1'b0, t_add);
      run_instr("sto",  STO, 1'b0, t_sto);
      run_instr("jmp",  JMP, 1'b0, t_jmp);
      run_instr("skz1", SKZ, 1'b1, t_skz1);
      run_instr("skz0", SKZ, 1'b0, t_skz0);

      // Same SKZ, zero flips only inside ALU_OP: only that cycle's inc_pc follows.
      bus.opcode = SKZ;
      bus.zero   = 1'b0;
      repeat (6) @(negedge clk);
      chk("skz alu z0", 7'b0000000);
      bus.zero = 1'b1;
      #1 chk("skz alu z1", 7'b0001000);
      @(negedge clk);
      chk("skz store", 7'b0000000);
      bus.zero = 1'b0;
      @(negedge clk);

      // Asynchronous reset in the middle of ALU_OP of an ADD.
      bus.opcode = ADD;
      repeat (6) @(negedge clk);
      chk("pre-rst alu_op", 7'b1000100);
      #2 rst = 1'b1;
      #1 chk("rst async", 7'b0000000);
      @(negedge clk);
      chk("rst held", 7'b0000000);
      rst = 1'b0;
      run_instr("add post-rst", ADD, 1'b0, t_add);
      chk("back at inst_addr", 7'b0000000);

      // HLT parks in OP_ADDR, ignores later opcode changes, only rst clears it.
      bus.opcode = HLT;
      for (int c = 0; c < 4; c++) begin
         chk($sformatf("hlt c%0d", c), t_add[c]);
         @(negedge clk);
      end
      chk("hlt c4", 7'b0010000);
      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         chk($sformatf("halted %0d", i), 7'b0010000);
      end
      bus.opcode = ADD;
      #1 chk("halted op change", 7'b0010000);
      @(negedge clk);
      chk("halted sticky", 7'b0010000);
      #2 rst = 1'b1;
      #1 chk("halt rst async", 7'b0000000);
      @(negedge clk);
      rst = 1'b0;
      run_instr("add after halt", ADD, 1'b0, t_add);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/controller_m.md
# controller_m

Instruction-sequencing FSM for the VeriRISC CPU, sitting directly upstream of the ALU. It steps through an eight-phase instruction cycle and drives the strobes for memory, the instruction register, the program counter and the accumulator. Decoding uses the current opcode from the instruction register and the ALU's `zero` flag. One instruction completes every eight clocks; a `HLT` instruction freezes the sequencer until reset.

## Interface
Parameters: none. The opcode width is fixed at 3 by the shared opcode type.

Ports:
- `clk`, input, 1: system clock. The state advances on the rising edge.
- `rst`, input, 1: reset. Asynchronous and active-high.
- `opcode`, input, 3: current instruction opcode from the IR (`opcode_t`).
- `zero`, input, 1: the ALU accumulator-is-zero flag.
- `mem_rd`, output, 1: memory read enable.
- `load_ir`, output, 1: instruction register load.
- `halt`, output, 1: CPU halted indication.
- `inc_pc`, output, 1: program counter increment.
- `load_ac`, output, 1: accumulator load (captures the ALU result).
- `load_pc`, output, 1: program counter load (jump).
- `mem_wr`, output, 1: memory write enable.

## Operation
State sequence, wrapping around: `INST_ADDR` → `INST_FETCH` → `INST_LOAD` → `IDLE` → `OP_ADDR` → `OP_FETCH` → `ALU_OP` → `STORE` → `INST_ADDR`.

Helper term: `aluop` = opcode is one of `ADD`, `AND`, `XOR`, `LDA`.

Outputs are combinational decodes of the registered state, `opcode` and `zero`. Every output not listed for a state is 0.
- `INST_ADDR`: all outputs 0.
- `INST_FETCH`: `mem_rd`=1.
- `INST_LOAD`: `mem_rd`=1, `load_ir`=1.
- `IDLE`: `mem_rd`=1, `load_ir`=1.
- `OP_ADDR`:
  - `inc_pc`=1.
  - `halt`=(opcode==`HLT`).
- `OP_FETCH`: `mem_rd`=`aluop`.
- `ALU_OP`:
  - `mem_rd`=`aluop`, `load_ac`=`aluop`.
  - `inc_pc`=(opcode==`SKZ` && `zero`).
  - `load_pc`=(opcode==`JMP`).
- `STORE`:
  - `mem_rd`=`aluop`, `load_ac`=`aluop`.
  - `inc_pc`=(opcode==`JMP`), `load_pc`=(opcode==`JMP`).
  - `mem_wr`=(opcode==`STO`).

Halt behaviour:
- In `OP_ADDR` with opcode==`HLT`, the FSM does not advance. It stays in `OP_ADDR` with `halt`=1.
- While halted, `inc_pc` is forced to 0.
- Only `rst` leaves the halted condition.

Boundary rules:
- `HLT` asserts no strobe other than `halt`.
- `SKZ` with `zero`=0 asserts no strobe in `ALU_OP` or `STORE`.
- Unused or illegal state encodings recover to `INST_ADDR` on the next edge, with all outputs 0.
- `opcode` and `zero` are sampled combinationally every cycle. Changes mid-instruction affect only the outputs of the current state.

## Timing
- Reset:
  - `rst`=1 forces the state to `INST_ADDR` immediately, without waiting for a clock edge.
  - All outputs go to 0 while `rst` is high.
  - After `rst` falls, the first rising edge moves the FSM to `INST_FETCH`.
- Reset asserted in any state, including halted, aborts the instruction with no further strobes.
- Latency:
  - 8 clocks per instruction. Each state lasts exactly one cycle; halted is the only exception.
  - `load_ir` is high for 2 consecutive cycles (`INST_LOAD`, `IDLE`).
  - `load_ac` is high for 2 consecutive cycles (`ALU_OP`, `STORE`).
- The ALU updates on the falling clock edge. Strobes are therefore stable across the falling edge inside each state, which gives a half cycle of setup for the ALU and the downstream registers.
- `mem_wr` is high for exactly one cycle (`STORE`) per `STO` instruction.

## Structure
- The shared package `ex_type_pkg` holds:
  - `opcode_t`, the existing enum: `HLT`, `SKZ`, `ADD`, `AND`, `XOR`, `LDA`, `STO`, `JMP`, encoded 0–7.
  - A new `state_t` enum (3 bits) with the eight phases above, `INST_ADDR`=0 through `STORE`=7.
  - The helper function `is_aluop(opcode_t)`.
- Single module: one `always_ff` block for the state register (async reset) and one `always_comb` block for the next-state and output decode.
- No sub-module.

## Test plan
- **Reset:** assert `rst` mid-cycle in `ALU_OP` with opcode=`ADD` → all outputs drop to 0 at once. After release, 8 edges return the FSM to `INST_ADDR`.
- **ADD:** opcode=`ADD`, `zero`=0, run 8 clocks:
  - `mem_rd` pattern 0,1,1,1,0,1,1,1.
  - `load_ac` high in cycles 6–7.
  - `mem_wr`=0 and `load_pc`=0 throughout.
- **STO:** opcode=`STO` → `mem_wr` high only in cycle 7 (`STORE`); `mem_rd`=0 in cycles 5–7.
- **JMP:** opcode=`JMP` → `load_pc`=1 in cycles 6–7, `inc_pc`=1 in cycles 4 and 7.
- **SKZ:**
  - `zero`=1 → `inc_pc`=1 in cycles 4 and 6.
  - `zero`=0 → `inc_pc`=1 only in cycle 4.
- **HLT:** opcode=`HLT` → `halt`=1 from cycle 4 onward. The state holds `OP_ADDR` for 20+ clocks with `inc_pc`=0. `rst` then clears `halt` asynchronously.
